// File: rtl/digit_scan_ctrl.sv
// Multiplexed display digit scanner: round-robin over enabled digits, each
// driven for a programmable dwell with a fixed all-off blanking gap between.
module digit_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DIV_W        = 18,
  parameter int unsigned DEFAULT_DIV  = 99999,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic [NUM_DIGITS-1:0]         digit_mask_i,
  input  logic [DIV_W-1:0]              div_i,
  input  logic                          div_load_i,
  output logic [NUM_DIGITS-1:0]         digit_en_o,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
  output logic                          tick_o,
  output logic                          busy_o
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0] BLANK_LOAD = DIV_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

  state_e                  state_q;
  logic [DIV_W-1:0]        cnt_q;
  logic [DIV_W-1:0]        div_q;
  logic [IW-1:0]           idx_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic                    tick_q;

  logic [IW-1:0]           first_idx;
  logic [IW-1:0]           next_idx;
  logic                    any_set;

  assign any_set = |digit_mask_i;

  always_comb begin
    first_idx = '0;
    for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
      if (digit_mask_i[IW'(i - 1)]) first_idx = IW'(i - 1);
    end
  end

  // Scan offsets downward so the nearest set bit after idx_q wins; offset
  // NUM_DIGITS wraps back onto idx_q itself for a single-digit mask.
  always_comb begin
    next_idx = idx_q;
    for (int unsigned k = NUM_DIGITS; k > 0; k--) begin
      if (digit_mask_i[IW'((32'(idx_q) + k) % NUM_DIGITS)])
        next_idx = IW'((32'(idx_q) + k) % NUM_DIGITS);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_W'(DEFAULT_DIV);
      idx_q   <= '0;
      en_q    <= '0;
      tick_q  <= 1'b0;
    end else begin
      if (div_load_i) div_q <= div_i;
      tick_q <= 1'b0;
      if (!enable_i) begin
        state_q <= IDLE;
        en_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (any_set) begin
              idx_q   <= first_idx;
              cnt_q   <= BLANK_LOAD;
              state_q <= BLANK;
            end
          end
          BLANK: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - DIV_W'(1);
            end else begin
              state_q <= DRIVE;
              cnt_q   <= div_q;
              en_q    <= NUM_DIGITS'(1) << idx_q;
              tick_q  <= 1'b1;
            end
          end
          DRIVE: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - DIV_W'(1);
            end else begin
              en_q <= '0;
              if (any_set) begin
                idx_q   <= next_idx;
                cnt_q   <= BLANK_LOAD;
                state_q <= BLANK;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          default: begin
            state_q <= IDLE;
            en_q    <= '0;
          end
        endcase
      end
    end
  end

  assign digit_en_o  = en_q;
  assign digit_idx_o = idx_q;
  assign tick_o      = tick_q;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: doc/digit_scan_ctrl.md
DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of multiplexed display digits (2..8).
REQ-002 SHALL have parameter DIV_W, default 18, width of the dwell-period register.
REQ-003 SHALL have parameter DEFAULT_DIV, default 99999, dwell period after reset (dwell = DEFAULT_DIV+1 clk cycles).
REQ-004 SHALL have parameter BLANK_CYCLES, default 8, all-digits-off gap between digits (>=1).
REQ-005 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-007 SHALL have port enable_i  input  1  scan run request, level.
REQ-008 SHALL have port digit_mask_i  input  NUM_DIGITS  1 = digit participates in scan.
REQ-009 SHALL have port div_i  input  DIV_W  new dwell period minus one.
REQ-010 SHALL have port div_load_i  input  1  single-cycle strobe capturing div_i.
REQ-011 SHALL have port digit_en_o  output  NUM_DIGITS  one-hot active-high digit drive, registered.
REQ-012 SHALL have port digit_idx_o  output  $clog2(NUM_DIGITS)  index of digit currently/next driven, registered.
REQ-013 SHALL have port tick_o  output  1  one-cycle pulse on first cycle of each DRIVE, registered.
REQ-014 SHALL have port busy_o  output  1  high whenever state != IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, BLANK, DRIVE and one DIV_W-bit down-counter shared by BLANK and DRIVE.
REQ-016 SHALL hold div_q register; div_load_i=1 loads div_q<=div_i next edge, in any state.
REQ-017 SHALL, in IDLE, with enable_i=1 and digit_mask_i!=0, select lowest-index set mask bit, load counter BLANK_CYCLES-1, go BLANK; else stay IDLE.
REQ-018 SHALL, in BLANK, drive digit_en_o=0; counter!=0 -> decrement; counter==0 -> go DRIVE, load counter with div_q.
REQ-019 SHALL, in DRIVE, assert digit_en_o[digit_idx_o] only, tick_o=1 on first DRIVE cycle only.
REQ-020 SHALL keep DRIVE exactly div_q+1 cycles and BLANK exactly BLANK_CYCLES cycles; div_q=0 gives 1-cycle DRIVE.
REQ-021 SHALL, at DRIVE counter==0, pick next set mask bit searching idx+1 upward with wrap to 0 (round-robin), load BLANK_CYCLES-1, go BLANK.
REQ-022 SHALL, with single set mask bit, reselect the same digit with BLANK gap between each DRIVE.
REQ-023 SHALL sample digit_mask_i only at selection points (REQ-017, REQ-021); mask change mid-DRIVE never truncates current dwell.
REQ-024 SHALL go IDLE instead of BLANK if digit_mask_i==0 at a selection point.
REQ-025 SHALL go IDLE on the edge after enable_i=0 from any state; digit_en_o=0, tick_o=0 that same edge.
REQ-026 SHALL use div_q value present at DRIVE entry; div_load_i in same cycle as DRIVE entry affects the next DRIVE only.
REQ-027 SHALL never assert more than one digit_en_o bit, and never assert digit_en_o in BLANK or IDLE.
REQ-028 SHALL change digit_idx_o only at selection points; it holds during BLANK and DRIVE.

Reset
REQ-029 SHALL, on rst_ni=0 asynchronously: state=IDLE, counter=0, div_q=DEFAULT_DIV, digit_idx_o=0, digit_en_o=0, tick_o=0, busy_o=0.
REQ-030 SHALL resume from IDLE per REQ-017 on first edge after rst_ni release; reset mid-DRIVE drops digit drive immediately.

Verification
REQ-031 SHALL cover: NUM_DIGITS=4, BLANK_CYCLES=2, load div 3, mask 1111, enable -> digit_en_o 0001,0010,0100,1000,0001 each 4 cycles high, 2 cycles all-zero between, tick_o once per DRIVE.
REQ-032 SHALL cover: mask 0101, div 0 -> sequence 0001,0100,0001 each 1 cycle, idx 0,2,0.
REQ-033 SHALL cover: mask 1111->0010 mid-DRIVE of digit 0 -> digit 0 completes full dwell, next DRIVE is 0010 then 0010 repeated.
REQ-034 SHALL cover: div_load_i with div_i=7 during DRIVE at div 3 -> current DRIVE 4 cycles, next DRIVE 8 cycles.
REQ-035 SHALL cover: enable_i=0 mid-DRIVE -> next edge digit_en_o=0, busy_o=0; mask 0000 at enable -> stays IDLE, no tick_o.
REQ-036 SHALL cover: rst_ni low asynchronously mid-DRIVE -> outputs zero before next edge, div_q back to 99999 (5-cycle check with div reload skipped).
